shared_alu_arbiter: RTL and testbench

Round-robin controller that shares one 8-bit adder/subtractor between the PLC cores of the multicore unit. Each core posts an operation with a request/grant/done handshake; the arbiter latches the winner's operands, runs the operation in one registered stage and returns the result. It holds one overflow (carry-out) flag per core, so the shared arithmetic datapath keeps per-core overflow state.

---
 rtl/shared_alu_arbiter_pkg.sv | 6 +
 rtl/shared_alu_arbiter_if.sv | 26 ++
 rtl/shared_alu_arbiter_rr_pick.sv | 17 +
 rtl/shared_alu_arbiter.sv | 83 ++++++++
 tb/tb_shared_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_alu_arbiter_pkg.sv
// shared_alu_arbiter_pkg: op codes, FSM states and default width shared by the arbiter slice.
package shared_alu_arbiter_pkg;
   localparam int DATA_W_DEF = 8;
   typedef enum logic [1:0] {OP_SUB = 2'b00, OP_ADD = 2'b01, OP_CLR_OV = 2'b10, OP_NOP = 2'b11} op_t;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/shared_alu_arbiter_if.sv
// shared_alu_arbiter_if: per-core request/grant/done bus between the cores and the shared ALU arbiter.
interface shared_alu_arbiter_if
   import shared_alu_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = DATA_W_DEF
);
   logic [NUM_CORES-1:0]        Core_Req;
   logic [2*NUM_CORES-1:0]      Core_Op;
   logic [DATA_W*NUM_CORES-1:0] Core_A;
   logic [DATA_W*NUM_CORES-1:0] Core_B;
   logic [NUM_CORES-1:0]        Core_Lock;
   logic [NUM_CORES-1:0]        Core_Grant;
   logic [NUM_CORES-1:0]        Core_Done;
   logic [DATA_W-1:0]           Core_Result;
   logic [NUM_CORES-1:0]        Core_OV;
   logic                        ALU_Busy;
   modport master (
      output Core_Req, Core_Op, Core_A, Core_B, Core_Lock,
      input  Core_Grant, Core_Done, Core_Result, Core_OV, ALU_Busy
   );
   modport slave (
      input  Core_Req, Core_Op, Core_A, Core_B, Core_Lock,
      output Core_Grant, Core_Done, Core_Result, Core_OV, ALU_Busy
   );
endinterface

// File: rtl/shared_alu_arbiter_rr_pick.sv
// shared_alu_arbiter_rr_pick: combinational round-robin select of the first requester at or after the pointer.
module shared_alu_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);
   always_comb begin
      o_idx   = '0;
      o_valid = |i_req;
      for (int i = N - 1; i >= 0; i--)
         if (i_req[(int'(i_ptr) + i) % N]) o_idx = IW'((int'(i_ptr) + i) % N);
   end
endmodule

// File: rtl/shared_alu_arbiter.sv
// shared_alu_arbiter: round-robin sharing of one add/sub stage with per-core overflow flags; ALU_ARB_LOCK_EN enables ownership lock.
module shared_alu_arbiter
   import shared_alu_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = DATA_W_DEF
) (
   input logic                 CLK,
   input logic                 CPU_Reset,
   shared_alu_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_CORES);
   state_t               r_state, w_next;
   op_t                  r_op;
   logic [IW-1:0]        r_idx, r_ptr, w_idx, w_inc, w_ptr_nxt;
   logic                 w_valid, w_sub, w_arith;
   logic [DATA_W-1:0]    r_a, r_b, r_result;
   logic [NUM_CORES-1:0] r_ov, w_onehot;
   logic [DATA_W:0]      w_sum;

   shared_alu_arbiter_rr_pick #(.N(NUM_CORES), .IW(IW)) u_pick (
      .i_req   (bus.Core_Req),
      .i_ptr   (r_ptr),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   assign w_onehot = NUM_CORES'(1) << r_idx;
   assign w_sub    = r_op == OP_SUB;
   assign w_arith  = r_op == OP_ADD || r_op == OP_SUB;
   assign w_sum    = {1'b0, r_a} + {1'b0, w_sub ? ~r_b : r_b} + (DATA_W+1)'(w_sub);
   assign w_inc    = int'(r_idx) == NUM_CORES - 1 ? '0 : r_idx + 1'b1;

`ifdef ALU_ARB_LOCK_EN
   // Parking the pointer on the owner makes it the first candidate next time.
   assign w_ptr_nxt = bus.Core_Lock[r_idx] ? r_idx : w_inc;
`else
   logic w_unused;
   assign w_unused  = ^bus.Core_Lock;
   assign w_ptr_nxt = w_inc;
`endif

   assign bus.Core_Result = r_result;
   assign bus.Core_OV     = r_ov;

   always_ff @(posedge CLK) begin
      if (CPU_Reset) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state == S_IDLE ? (w_valid ? S_EXEC : S_IDLE) :
                       r_state == S_EXEC ? S_RESP : S_IDLE;
      bus.Core_Grant = r_state == S_EXEC ? w_onehot : '0;
      bus.Core_Done  = r_state == S_RESP ? w_onehot : '0;
      bus.ALU_Busy   = r_state != S_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (CPU_Reset) begin
         r_ptr    <= '0;
         r_idx    <= '0;
         r_op     <= OP_NOP;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_ov     <= '0;
      end else begin
         if (r_state == S_IDLE && w_valid) begin
            r_idx <= w_idx;
            r_op  <= op_t'(bus.Core_Op[2*w_idx +: 2]);
            r_a   <= bus.Core_A[DATA_W*w_idx +: DATA_W];
            r_b   <= bus.Core_B[DATA_W*w_idx +: DATA_W];
         end
         if (r_state == S_EXEC && w_arith) begin
            r_result     <= w_sum[DATA_W-1:0];
            r_ov[r_idx]  <= w_sum[DATA_W];
         end
         if (r_state == S_EXEC && r_op == OP_CLR_OV) r_ov[r_idx] <= 1'b0;
         if (r_state == S_RESP) r_ptr <= w_ptr_nxt;
      end
   end
endmodule

// File: tb/tb_shared_alu_arbiter.sv
// tb_shared_alu_arbiter: scoreboard bench for the shared ALU arbiter (default build or ALU_ARB_LOCK_EN).
module tb_shared_alu_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      int           core;
      logic [W-1:0] res;
      logic [N-1:0] ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   exp_t         exp_q[$];
   logic [N-1:0] m_ov = '0;
   logic [W-1:0] m_res = '0;
   int           reps[N];
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   shared_alu_arbiter_if #(.NUM_CORES(N), .DATA_W(W)) bus ();

   shared_alu_arbiter #(.NUM_CORES(N), .DATA_W(W)) dut (
      .CLK       (clk),
      .CPU_Reset (rst),
      .bus       (bus)
   );

   task automatic set_op(input int c, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      bus.Core_Op[2*c +: 2] = o;
      bus.Core_A[W*c +: W]  = av;
      bus.Core_B[W*c +: W]  = bv;
   endtask

   // Model in expected completion order; SUB carry is "no borrow" (a >= b).
   task automatic expect_op(input int c, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [W:0] s;
      if (o == 2'b01) begin
         s = {1'b0, av} + {1'b0, bv};
         m_res = s[W-1:0];
         m_ov[c] = s[W];
      end else if (o == 2'b00) begin
         s = 9'h100 + {1'b0, av} - {1'b0, bv};
         m_res = s[W-1:0];
         m_ov[c] = av >= bv;
      end else if (o == 2'b10) m_ov[c] = 1'b0;
      exp_q.push_back('{c, m_res, m_ov});
      reps[c]++;
   endtask

   task automatic fire(input logic [N-1:0] mask);
      @(posedge clk);
      #1 bus.Core_Req = bus.Core_Req | mask;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      bus.Core_Req = '0;
      m_ov = '0;
      m_res = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run_ops(input int budget, output int first_g);
      int   cyc;
      int   gcyc;
      exp_t e;
      logic [N-1:0] eg;
      cyc = 0;
      gcyc = -10;
      first_g = -1;
      while (exp_q.size() > 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (bus.Core_Grant != '0) begin
            eg = '0;
            eg[exp_q[0].core] = 1'b1;
            checks++;
            if (bus.Core_Grant !== eg) begin
               failures++;
               $display("FAIL grant_order: got %b want %b", bus.Core_Grant, eg);
            end
            checks++;
            if (bus.ALU_Busy !== 1'b1) begin
               failures++;
               $display("FAIL busy_exec: got %b want 1", bus.ALU_Busy);
            end
            if (first_g < 0) first_g = cyc;
            gcyc = cyc;
            // Operand changes after the grant must not affect the captured op.
            if (reps[exp_q[0].core] == 1)
               bus.Core_A[W*exp_q[0].core +: W] = ~bus.Core_A[W*exp_q[0].core +: W];
         end
         if (bus.Core_Done != '0) begin
            e = exp_q.pop_front();
            eg = '0;
            eg[e.core] = 1'b1;
            checks++;
            if (bus.Core_Done !== eg) begin
               failures++;
               $display("FAIL done_core: got %b want %b", bus.Core_Done, eg);
            end
            checks++;
            if (cyc != gcyc + 1) begin
               failures++;
               $display("FAIL done_latency: got %0d want %0d", cyc - gcyc, 1);
            end
            checks++;
            if (bus.Core_Result !== e.res) begin
               failures++;
               $display("FAIL result core%0d: got %h want %h", e.core, bus.Core_Result, e.res);
            end
            checks++;
            if (bus.Core_OV !== e.ov) begin
               failures++;
               $display("FAIL ov core%0d: got %b want %b", e.core, bus.Core_OV, e.ov);
            end
            reps[e.core]--;
            if (reps[e.core] == 0) bus.Core_Req[e.core] = 1'b0;
         end
      end
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL timeout: got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.Core_Grant !== '0 || bus.Core_Done !== '0) begin
            failures++;
            $display("FAIL spurious: got grant=%b done=%b want 0", bus.Core_Grant, bus.Core_Done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.Core_Grant, bus.Core_Done, bus.Core_Result, bus.Core_OV, bus.ALU_Busy} !== '0) begin
         failures++;
         $display("FAIL reset_state: got g=%b d=%b r=%h ov=%b busy=%b want 0", bus.Core_Grant,
                  bus.Core_Done, bus.Core_Result, bus.Core_OV, bus.ALU_Busy);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_add();
      int fg;
      set_op(1, 2'b01, 8'hF0, 8'h20);
      expect_op(1, 2'b01, 8'hF0, 8'h20);
      fire(4'b0010);
      run_ops(20, fg);
      checks++;
      if (fg != 2) begin
         failures++;
         $display("FAIL grant_latency: got %0d want 2", fg);
      end
   endtask

   task automatic test_sub();
      int fg;
      set_op(2, 2'b00, 8'h05, 8'h07);
      expect_op(2, 2'b00, 8'h05, 8'h07);
      fire(4'b0100);
      run_ops(20, fg);
      set_op(2, 2'b00, 8'h07, 8'h05);
      expect_op(2, 2'b00, 8'h07, 8'h05);
      fire(4'b0100);
      run_ops(20, fg);
   endtask

   task automatic test_all4();
      int fg;
      do_reset();
      set_op(0, 2'b01, 8'h01, 8'h02);
      set_op(1, 2'b01, 8'h7F, 8'h01);
      set_op(2, 2'b01, 8'hFF, 8'hFF);
      set_op(3, 2'b01, 8'hC0, 8'h50);
      expect_op(0, 2'b01, 8'h01, 8'h02);
      expect_op(1, 2'b01, 8'h7F, 8'h01);
      expect_op(2, 2'b01, 8'hFF, 8'hFF);
      expect_op(3, 2'b01, 8'hC0, 8'h50);
      fire(4'b1111);
      run_ops(60, fg);
   endtask

   task automatic test_clr_nop();
      int fg;
      set_op(0, 2'b01, 8'hFF, 8'h03);
      expect_op(0, 2'b01, 8'hFF, 8'h03);
      fire(4'b0001);
      run_ops(20, fg);
      set_op(0, 2'b10, 8'h11, 8'h22);
      expect_op(0, 2'b10, 8'h11, 8'h22);
      fire(4'b0001);
      run_ops(20, fg);
      set_op(1, 2'b11, 8'h33, 8'h44);
      expect_op(1, 2'b11, 8'h33, 8'h44);
      fire(4'b0010);
      run_ops(20, fg);
   endtask

   task automatic test_reset_abort();
      int   fg;
      logic seen;
      seen = 1'b0;
      set_op(3, 2'b01, 8'h90, 8'h90);
      fire(4'b1000);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.Core_Grant[3]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL abort_grant: got 0 want 1");
      end
      rst = 1'b1;
      bus.Core_Req = '0;
      m_ov = '0;
      m_res = '0;
      @(negedge clk);
      checks++;
      if ({bus.Core_Grant, bus.Core_Done, bus.Core_Result, bus.Core_OV, bus.ALU_Busy} !== '0) begin
         failures++;
         $display("FAIL abort_state: got g=%b d=%b r=%h ov=%b busy=%b want 0", bus.Core_Grant,
                  bus.Core_Done, bus.Core_Result, bus.Core_OV, bus.ALU_Busy);
      end
      rst = 1'b0;
      set_op(0, 2'b11, 8'h00, 8'h00);
      set_op(3, 2'b11, 8'h00, 8'h00);
      expect_op(0, 2'b11, 8'h00, 8'h00);
      expect_op(3, 2'b11, 8'h00, 8'h00);
      fire(4'b1001);
      run_ops(30, fg);
   endtask

   task automatic test_lock();
      int fg;
      bus.Core_Lock = 4'b0100;
      set_op(2, 2'b01, 8'h01, 8'h01);
      set_op(3, 2'b00, 8'h09, 8'h01);
      expect_op(2, 2'b01, 8'h01, 8'h01);
`ifdef ALU_ARB_LOCK_EN
      expect_op(2, 2'b01, 8'h01, 8'h01);
`endif
      expect_op(3, 2'b00, 8'h09, 8'h01);
      fire(4'b1100);
      run_ops(40, fg);
      bus.Core_Lock = '0;
   endtask

   initial begin
      bus.Core_Req  = '0;
      bus.Core_Op   = '1;
      bus.Core_A    = '0;
      bus.Core_B    = '0;
      bus.Core_Lock = '0;
      for (int i = 0; i < N; i++) reps[i] = 0;
      test_reset();
      test_add();
      test_sub();
      test_all4();
      test_clr_nop();
      test_reset_abort();
      test_lock();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
